// File: rtl/vip_pkg.sv
// Shared constants, clog2 helper and pixel-position type for the vip input path.
package vip_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int NUM_CH_DEF = 8;
  localparam int POS_W      = 16;

  typedef struct packed {
    logic [POS_W-1:0] col;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] img;
  } pos_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count and sticky overflow flag.
module sync_fifo_fwft
  import vip_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] next_count,
  output logic          overflow
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  always_comb begin
    pop     = rd_en && (count_q != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    push    = wr_en && ((count_q != CW'(DEPTH)) || pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (wr_en && !push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rptr_q];
  assign count      = count_q;
  assign next_count = count_d;
  assign overflow   = ovf_q;

endmodule

// File: rtl/chan_in_rx.sv
// Pixel-feed receive port: FWFT buffer, back-pressure, channel packing and position markers.
// Optional CHAN_IN_RX_STATS_EN adds stall-cycle and high-watermark statistics outputs.
// Stream handshake: a head pixel transfers on any cycle with out_valid && out_ready.
module chan_in_rx
  import vip_pkg::*;
#(
  parameter  int DWIDTH      = DWIDTH_DEF,
  parameter  int NUM_CH      = NUM_CH_DEF,
  parameter  int DEPTH       = 16,
  parameter  int FULL_MARGIN = 2,
  parameter  int WIDTH       = 28,
  parameter  int HEIGHT      = 28,
  parameter  int NUM_IMG     = 1,
  localparam int IMG_W       = clog2(NUM_IMG) + 1,
  localparam int FILL_W      = clog2(DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DWIDTH-1:0]        fifo_in_data_0,
  input  logic [DWIDTH-1:0]        fifo_in_data_1,
  input  logic [DWIDTH-1:0]        fifo_in_data_2,
  input  logic [DWIDTH-1:0]        fifo_in_data_3,
  input  logic [DWIDTH-1:0]        fifo_in_data_4,
  input  logic [DWIDTH-1:0]        fifo_in_data_5,
  input  logic [DWIDTH-1:0]        fifo_in_data_6,
  input  logic [DWIDTH-1:0]        fifo_in_data_7,
  input  logic                     fifo_in_wrreq,
  output logic                     fifo_in_full,
  output logic [NUM_CH*DWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sol,
  output logic                     out_eol,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic [IMG_W-1:0]         out_img_idx,
  output logic                     done,
`ifdef CHAN_IN_RX_STATS_EN
  output logic [31:0]              stat_stall_cycles,
  output logic [FILL_W-1:0]        stat_max_fill,
`endif
  output logic                     overflow_err
);

  localparam int COL_W = clog2(WIDTH + 1);
  localparam int ROW_W = clog2(HEIGHT + 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [IMG_W-1:0]  IMG_LAST = IMG_W'(NUM_IMG - 1);
  localparam logic [FILL_W-1:0] FULL_TH  = FILL_W'(DEPTH - FULL_MARGIN);

  logic [DWIDTH-1:0]        ch_in [8];
  logic [NUM_CH*DWIDTH-1:0] wr_pix;
  logic [FILL_W-1:0]        fill_count, fill_next;
  logic                     pop;

  logic             full_q, full_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IMG_W-1:0] img_q, img_d;
  logic             done_q, done_d;

  assign ch_in[0] = fifo_in_data_0;
  assign ch_in[1] = fifo_in_data_1;
  assign ch_in[2] = fifo_in_data_2;
  assign ch_in[3] = fifo_in_data_3;
  assign ch_in[4] = fifo_in_data_4;
  assign ch_in[5] = fifo_in_data_5;
  assign ch_in[6] = fifo_in_data_6;
  assign ch_in[7] = fifo_in_data_7;

  always_comb begin
    wr_pix = '0;
    for (int k = 0; k < NUM_CH; k++) wr_pix[k*DWIDTH +: DWIDTH] = ch_in[k];
  end

  sync_fifo_fwft #(
    .W     (NUM_CH * DWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clock),
    .rst        (reset),
    .wr_en      (fifo_in_wrreq),
    .wr_data    (wr_pix),
    .rd_en      (out_ready),
    .rd_data    (out_data),
    .count      (fill_count),
    .next_count (fill_next),
    .overflow   (overflow_err)
  );

  assign out_valid = (fill_count != '0);
  assign pop       = out_valid && out_ready;

  // Position advances only on a pop, so markers always describe the head pixel.
  always_comb begin
    full_d = (fill_next >= FULL_TH);
    col_d  = col_q;
    row_d  = row_q;
    img_d  = img_q;
    done_d = done_q;
    if (pop) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (img_q == IMG_LAST) begin
            img_d  = '0;
            done_d = 1'b1;
          end else begin
            img_d = img_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
      img_q  <= '0;
      done_q <= 1'b0;
    end else begin
      full_q <= full_d;
      col_q  <= col_d;
      row_q  <= row_d;
      img_q  <= img_d;
      done_q <= done_d;
    end
  end

  assign fifo_in_full = full_q;
  assign out_sol      = out_valid && (col_q == '0);
  assign out_eol      = out_valid && (col_q == COL_LAST);
  assign out_sof      = out_sol && (row_q == '0);
  assign out_eof      = out_eol && (row_q == ROW_LAST);
  assign out_img_idx  = img_q;
  assign done         = done_q;

`ifdef CHAN_IN_RX_STATS_EN
  logic [31:0]       stall_q, stall_d;
  logic [FILL_W-1:0] max_fill_q, max_fill_d;

  always_comb begin
    stall_d    = stall_q;
    max_fill_d = max_fill_q;
    if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (fill_count > max_fill_q) max_fill_d = fill_count;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q    <= '0;
      max_fill_q <= '0;
    end else begin
      stall_q    <= stall_d;
      max_fill_q <= max_fill_d;
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_max_fill     = max_fill_q;
`endif

endmodule

// File: tb/tb_chan_in_rx.sv
// Self-checking bench for chan_in_rx built with WIDTH=4, HEIGHT=2, NUM_IMG=2, DEPTH=16.
module tb_chan_in_rx;
  import vip_pkg::*;

  localparam int DW    = 32;
  localparam int NC    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = NC * DW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din [NC];
  logic          fifo_in_wrreq = 1'b0;
  logic          fifo_in_full;
  logic [PW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_sol, out_eol, out_sof, out_eof;
  logic [1:0]    out_img_idx;
  logic          done;
  logic          overflow_err;
`ifdef CHAN_IN_RX_STATS_EN
  logic [31:0]   stat_stall_cycles;
  logic [4:0]    stat_max_fill;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clock = ~clock;

  chan_in_rx #(
    .DWIDTH(DW), .NUM_CH(NC), .DEPTH(DEPTH), .FULL_MARGIN(2),
    .WIDTH(4), .HEIGHT(2), .NUM_IMG(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_data_0 (din[0]),
    .fifo_in_data_1 (din[1]),
    .fifo_in_data_2 (din[2]),
    .fifo_in_data_3 (din[3]),
    .fifo_in_data_4 (din[4]),
    .fifo_in_data_5 (din[5]),
    .fifo_in_data_6 (din[6]),
    .fifo_in_data_7 (din[7]),
    .fifo_in_wrreq  (fifo_in_wrreq),
    .fifo_in_full   (fifo_in_full),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sol        (out_sol),
    .out_eol        (out_eol),
    .out_sof        (out_sof),
    .out_eof        (out_eof),
    .out_img_idx    (out_img_idx),
    .done           (done),
`ifdef CHAN_IN_RX_STATS_EN
    .stat_stall_cycles (stat_stall_cycles),
    .stat_max_fill     (stat_max_fill),
`endif
    .overflow_err   (overflow_err)
  );

  typedef struct {
    logic wr;
    logic rd;
    int   v;
    logic e_valid;
    logic e_full;
    int   e_v;
    logic e_sol;
    logic e_eol;
    logic e_sof;
    logic e_eof;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [PW-1:0] pix(input int v);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++) r[k*DW +: DW] = DW'(k * 1000 + v);
    return r;
  endfunction

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input int v);
    fifo_in_wrreq = wr;
    out_ready     = rd;
    for (int k = 0; k < NC; k++) din[k] = DW'(k * 1000 + v);
  endtask

  task automatic cyc(input logic wr, input logic rd, input int v);
    drive(wr, rd, v);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int nxt;
    logic wr, rd;

    tbl[0] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 4, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 5, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    check("rst_valid", out_valid, 0);
    check("rst_full", fifo_in_full, 0);
    check("rst_img", out_img_idx, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow_err, 0);

    // Vector table: short writes, pops, line wrap
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].wr, tbl[i].rd, tbl[i].v);
      check($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("vec%0d_full", i), fifo_in_full, tbl[i].e_full);
      check($sformatf("vec%0d_sol", i), out_sol, tbl[i].e_sol);
      check($sformatf("vec%0d_eol", i), out_eol, tbl[i].e_eol);
      check($sformatf("vec%0d_sof", i), out_sof, tbl[i].e_sof);
      check($sformatf("vec%0d_eof", i), out_eof, tbl[i].e_eof);
      if (tbl[i].e_valid) check($sformatf("vec%0d_data", i), out_data, pix(tbl[i].e_v));
    end

    // Fill to the threshold, then to full, then overflow
    do_reset();
    for (int n = 1; n <= DEPTH; n++) begin
      cyc(1'b1, 1'b0, n);
      check($sformatf("fill%0d_full", n), fifo_in_full, (n >= 14));
    end
    check("fill_ovf_before", overflow_err, 0);
    cyc(1'b1, 1'b0, 99);
    check("ovf_set", overflow_err, 1);
    check("ovf_full", fifo_in_full, 1);
    check("ovf_head", out_data, pix(1));
    for (int n = 1; n <= DEPTH; n++) begin
      check($sformatf("drain%0d_data", n), out_data, pix(n));
      cyc(1'b0, 1'b1, 0);
      check($sformatf("drain%0d_full", n), fifo_in_full, ((DEPTH - n) >= 14));
    end
    check("drain_empty", out_valid, 0);

    // Push and pop together at count==DEPTH
    do_reset();
    for (int n = 1; n <= DEPTH; n++) begin
      exp_q.push_back(pix(n));
      cyc(1'b1, 1'b0, n);
    end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("pp%0d_data", i), out_data, exp_q.pop_front());
      exp_q.push_back(pix(17 + i));
      cyc(1'b1, 1'b1, 17 + i);
      check($sformatf("pp%0d_ovf", i), overflow_err, 0);
      check($sformatf("pp%0d_full", i), fifo_in_full, 1);
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      check("pp_drain_data", out_data, exp_q.pop_front());
      cyc(1'b0, 1'b1, 0);
    end
    check("pp_drain_left", exp_q.size(), 0);
    check("pp_drain_empty", out_valid, 0);

    // Two 4x2 images: line, frame and batch markers
    do_reset();
    for (int n = 1; n <= DEPTH; n++) cyc(1'b1, 1'b0, n);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("pos%0d_data", i), out_data, pix(i));
      check($sformatf("pos%0d_sol", i), out_sol, (i % 4 == 1));
      check($sformatf("pos%0d_eol", i), out_eol, (i % 4 == 0));
      check($sformatf("pos%0d_sof", i), out_sof, (i % 8 == 1));
      check($sformatf("pos%0d_eof", i), out_eof, (i % 8 == 0));
      check($sformatf("pos%0d_img", i), out_img_idx, (i > 8) ? 1 : 0);
      check($sformatf("pos%0d_done", i), done, 0);
      cyc(1'b0, 1'b1, 0);
    end
    check("batch_done", done, 1);
    check("batch_img_wrap", out_img_idx, 0);
    cyc(1'b1, 1'b0, 77);
    check("batch_restart_sof", out_sof, 1);
    check("batch_done_sticky", done, 1);

    // Random ready and write gaps: lossless, ordered, lanes mapped
    do_reset();
    exp_q.delete();
    nxt = 1;
    for (int c = 0; c < 400; c++) begin
      wr = ($urandom_range(0, 2) != 0) && !fifo_in_full;
      rd = ($urandom_range(0, 1) == 1);
      if (out_valid && rd) begin
        if (exp_q.size() == 0) check("rnd_spurious", out_valid, 0);
        else check("rnd_data", out_data, exp_q.pop_front());
      end
      if (wr) exp_q.push_back(pix(nxt));
      cyc(wr, rd, nxt);
      if (wr) nxt++;
    end
    for (int c = 0; c < 40 && out_valid; c++) begin
      if (exp_q.size() == 0) check("rnd_spurious", out_valid, 0);
      else check("rnd_drain_data", out_data, exp_q.pop_front());
      cyc(1'b0, 1'b1, 0);
    end
    check("rnd_left", exp_q.size(), 0);
    check("rnd_ovf", overflow_err, 0);

    // Reset mid-image with five entries buffered
    do_reset();
    for (int n = 1; n <= 7; n++) cyc(1'b1, 1'b0, n);
    cyc(1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 0);
    check("mid_head", out_data, pix(3));
    drive(1'b1, 1'b1, 50);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_full", fifo_in_full, 0);
    check("mid_rst_img", out_img_idx, 0);
    cyc(1'b1, 1'b0, 60);
    check("mid_first_valid", out_valid, 1);
    check("mid_first_sof", out_sof, 1);
    check("mid_first_sol", out_sol, 1);
    check("mid_first_data", out_data, pix(60));
    cyc(1'b0, 1'b1, 0);
    check("mid_after_pop", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
